// File: rtl/alu_tree_writeback_if.sv
// Capture and register-bank write channels between the ALU tree and its writeback buffer.
// The slave modport is the writeback block; master is the tree/bank side.
interface alu_tree_writeback_if #(
    parameter int unsigned N_ALU  = 7,
    parameter int unsigned WORD_W = 32,
    parameter int unsigned TAG_W  = 4,
    parameter int unsigned IDX_W  = $clog2(N_ALU)
);
    logic                          cap_vld;
    logic                          cap_rdy;
    logic [N_ALU-1:0]              tree_out_vld;
    logic [N_ALU-1:0][WORD_W-1:0]  tree_out;
    logic [N_ALU-1:0]              wr_mask;
    logic [TAG_W-1:0]              cap_tag;
    logic                          wr_vld;
    logic                          wr_rdy;
    logic [WORD_W-1:0]             wr_data;
    logic [IDX_W-1:0]              wr_idx;
    logic [TAG_W-1:0]              wr_tag;
    logic                          wr_last;

    modport master (
        output cap_vld, tree_out_vld, tree_out, wr_mask, cap_tag, wr_rdy,
        input  cap_rdy, wr_vld, wr_data, wr_idx, wr_tag, wr_last
    );

    modport slave (
        input  cap_vld, tree_out_vld, tree_out, wr_mask, cap_tag, wr_rdy,
        output cap_rdy, wr_vld, wr_data, wr_idx, wr_tag, wr_last
    );
endinterface

// File: rtl/alu_tree_writeback.sv
// Buffers up to two ALU-tree result vectors and streams the masked words, lowest index
// first, to the register-bank write port one per cycle.
module alu_tree_writeback #(
    parameter int unsigned N_ALU  = 7,
    parameter int unsigned WORD_W = 32,
    parameter int unsigned TAG_W  = 4,
    parameter int unsigned IDX_W  = $clog2(N_ALU)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    alu_tree_writeback_if.slave bus
);
    typedef enum logic [0:0] {StIdle, StSend} state_e;

    state_e                        state_q, state_d;
    logic [N_ALU-1:0][WORD_W-1:0]  words_q [2];
    logic [N_ALU-1:0]              mask_q  [2];
    logic [TAG_W-1:0]              tag_q   [2];
    logic                          head_q, head_d;
    logic                          tail_q, tail_d;
    logic [1:0]                    count_q, count_d;
    logic [N_ALU-1:0]              r_q, r_d;

    logic [N_ALU-1:0] m;
    logic [N_ALU-1:0] r_low;
    logic [IDX_W-1:0] low_idx;
    logic             push, hs, final_word, pop;

    always_comb begin
        m          = bus.wr_mask & bus.tree_out_vld;
        // Empty effective masks are accepted but never occupy a slot.
        push       = bus.cap_vld && (count_q != 2'd2) && !flush && (m != '0);
        hs         = (state_q == StSend) && bus.wr_rdy;
        r_low      = r_q & (~r_q + N_ALU'(1));
        final_word = (r_q == r_low);
        pop        = hs && final_word;
        low_idx    = '0;
        for (int i = N_ALU - 1; i >= 0; i--) begin
            if (r_q[i]) low_idx = IDX_W'(i);
        end
    end

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        r_d     = r_q;
        if (flush) begin
            head_d  = 1'b0;
            tail_d  = 1'b0;
            count_d = 2'd0;
            r_d     = '0;
        end else begin
            if (push) tail_d = ~tail_q;
            if (pop)  head_d = ~head_q;
            count_d = count_q + {1'b0, push} - {1'b0, pop};
            if (pop) begin
                // Reload r from whichever entry becomes head on this edge.
                if (count_q == 2'd2) r_d = mask_q[~head_q];
                else if (push)       r_d = m;
                else                 r_d = '0;
            end else if (hs) begin
                r_d = r_q & ~r_low;
            end else if ((count_q == 2'd0) && push) begin
                r_d = m;
            end
        end
    end

    always_comb begin
        state_d = (count_d != 2'd0) ? StSend : StIdle;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            head_q  <= 1'b0;
            tail_q  <= 1'b0;
            count_q <= 2'd0;
            r_q     <= '0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            r_q     <= r_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            words_q[tail_q] <= bus.tree_out;
            mask_q[tail_q]  <= m;
            tag_q[tail_q]   <= bus.cap_tag;
        end
    end

    always_comb begin
        bus.cap_rdy = (count_q != 2'd2);
        bus.wr_vld  = 1'b0;
        bus.wr_data = '0;
        bus.wr_idx  = '0;
        bus.wr_tag  = '0;
        bus.wr_last = 1'b0;
        if (state_q == StSend) begin
            bus.wr_vld  = 1'b1;
            bus.wr_idx  = low_idx;
            bus.wr_data = words_q[head_q][low_idx];
            bus.wr_tag  = tag_q[head_q];
            bus.wr_last = final_word;
        end
    end
endmodule
